// File: rtl/mac_pkg.sv
// Shared types and defaults for the MAC array scheduler.
package mac_pkg;

    localparam int unsigned DefN     = 4;
    localparam int unsigned DefDataW = 8;
    localparam int unsigned DefKW    = 8;
    localparam int unsigned DefAddrW = 8;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StFeed,
        StDrain,
        StDone
    } state_e;

    // Drain length: read latency + (N-1) skew + (N-1) propagation + MAC register.
    function automatic int unsigned DRAIN_CYC(input int unsigned n);
        return 2 * n;
    endfunction

endpackage

// File: rtl/mac_array_sched_if.sv
// Host, operand-buffer and MAC-array signals of the scheduler.
interface mac_array_sched_if import mac_pkg::*; #(
    parameter int unsigned N      = DefN,
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned K_W    = DefKW,
    parameter int unsigned ADDR_W = DefAddrW
) ();

    logic                start;
    logic [K_W-1:0]      k_len;
    logic                busy;
    logic                done;
    logic                arr_clr;
    logic                rd_en;
    logic [ADDR_W-1:0]   rd_addr;
    logic [N*DATA_W-1:0] a_vec;
    logic [N*DATA_W-1:0] w_vec;
    logic [N*DATA_W-1:0] a_skew;
    logic [N*DATA_W-1:0] w_skew;

    // Host / buffer side driving the scheduler.
    modport master (
        output start, k_len, a_vec, w_vec,
        input  busy, done, arr_clr, rd_en, rd_addr, a_skew, w_skew
    );

    // Scheduler side.
    modport slave (
        input  start, k_len, a_vec, w_vec,
        output busy, done, arr_clr, rd_en, rd_addr, a_skew, w_skew
    );

endinterface

// File: rtl/mac_skew_line.sv
// Per-lane delay chains: lane i is delayed i cycles, zeroed when its valid is low.
module mac_skew_line #(
    parameter int unsigned N      = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid_i,
    input  logic [N*DATA_W-1:0] data_i,
    output logic [N*DATA_W-1:0] data_o
);

    logic [N*DATA_W-1:0] masked;

    // Masking before the delay equals delaying data and valid together then masking.
    always_comb begin
        masked = valid_i ? data_i : '0;
    end

    assign data_o[DATA_W-1:0] = masked[DATA_W-1:0];

    for (genvar i = 1; i < N; i++) begin : g_lane
        logic [DATA_W-1:0] pipe_q [i];

        // Shift chain of depth i, flushed by reset.
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int j = 0; j < i; j++) pipe_q[j] <= '0;
            end else begin
                pipe_q[0] <= masked[i*DATA_W +: DATA_W];
                for (int j = 1; j < i; j++) pipe_q[j] <= pipe_q[j-1];
            end
        end

        assign data_o[i*DATA_W +: DATA_W] = pipe_q[i-1];
    end

endmodule

// File: rtl/mac_array_sched.sv
// Job sequencer for an N-lane MAC array: clear, feed k terms, drain, pulse done.
// Optional MAC_SCHED_PERF_EN adds a busy-cycle counter output perf_cycles.
module mac_array_sched import mac_pkg::*; #(
    parameter int unsigned N      = DefN,
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned K_W    = DefKW,
    parameter int unsigned ADDR_W = DefAddrW
) (
    input  logic             clk,
    input  logic             rst,
    mac_array_sched_if.slave bus
`ifdef MAC_SCHED_PERF_EN
    ,
    output logic [31:0]      perf_cycles
`endif
);

    typedef logic [K_W-1:0] cnt_t;

    localparam cnt_t DrainLast = cnt_t'(DRAIN_CYC(N) - 1);

    state_e state_q, state_d;
    cnt_t   cnt_q, cnt_d;     // terms left in FEED, cycles left in DRAIN
    cnt_t   addr_q, addr_d;
    logic   dvalid_q;
    logic   busy, done, arr_clr, rd_en;
    logic   start_acc;

    assign start_acc = (state_q == StIdle) && bus.start;

    // State, counters and read-data valid register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            addr_q   <= '0;
            dvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            dvalid_q <= rd_en;
        end
    end

    // Next-state and decoded outputs.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        busy    = 1'b0;
        done    = 1'b0;
        arr_clr = 1'b0;
        rd_en   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    if (bus.k_len != '0) begin
                        state_d = StClear;
                        cnt_d   = bus.k_len - cnt_t'(1);
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StClear: begin
                busy    = 1'b1;
                arr_clr = 1'b1;
                addr_d  = '0;
                state_d = StFeed;
            end
            StFeed: begin
                busy  = 1'b1;
                rd_en = 1'b1;
                if (cnt_q == '0) begin
                    state_d = StDrain;
                    cnt_d   = DrainLast;
                end else begin
                    cnt_d  = cnt_q - cnt_t'(1);
                    addr_d = addr_q + cnt_t'(1);
                end
            end
            StDrain: begin
                busy = 1'b1;
                if (cnt_q == '0) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            StDone: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.busy    = busy;
    assign bus.done    = done;
    assign bus.arr_clr = arr_clr;
    assign bus.rd_en   = rd_en;
    assign bus.rd_addr = ADDR_W'(addr_q);

    mac_skew_line #(
        .N      (N),
        .DATA_W (DATA_W)
    ) u_skew_a (
        .clk     (clk),
        .rst     (rst),
        .valid_i (dvalid_q),
        .data_i  (bus.a_vec),
        .data_o  (bus.a_skew)
    );

    mac_skew_line #(
        .N      (N),
        .DATA_W (DATA_W)
    ) u_skew_w (
        .clk     (clk),
        .rst     (rst),
        .valid_i (dvalid_q),
        .data_i  (bus.w_vec),
        .data_o  (bus.w_skew)
    );

`ifdef MAC_SCHED_PERF_EN
    logic [31:0] perf_q, perf_d;

    // Busy-cycle counter: cleared on accept, saturating, holds while idle.
    always_comb begin
        perf_d = perf_q;
        if (start_acc) begin
            perf_d = '0;
        end else if (busy && (perf_q != '1)) begin
            perf_d = perf_q + 32'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) perf_q <= '0;
        else     perf_q <= perf_d;
    end

    assign perf_cycles = perf_q;
`else
    logic unused_start_acc;
    assign unused_start_acc = start_acc;
`endif

endmodule

// File: tb/tb_mac_array_sched.sv
// Scoreboard bench for mac_array_sched (N=4, DATA_W=8).
module tb_mac_array_sched;

    localparam int N  = 4;
    localparam int DW = 8;

    typedef struct {
        int c;
        int lane;
        int a;
        int w;
    } skew_t;

    logic clk;
    logic rst;
    int   cyc;
    bit   mon_en;
    int   checks;
    int   failures;

    int    clr_q[$];
    int    busy_q[$];
    int    done_q[$];
    int    rd_cyc_q[$];
    int    rd_addr_q[$];
    skew_t skew_q[$];

    mac_array_sched_if #(.N(N), .DATA_W(DW), .K_W(8), .ADDR_W(8)) bus ();

`ifdef MAC_SCHED_PERF_EN
    logic [31:0] perf_cycles;
`endif

    mac_array_sched #(.N(N), .DATA_W(DW), .K_W(8), .ADDR_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef MAC_SCHED_PERF_EN
        ,
        .perf_cycles (perf_cycles)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Operand buffer model: lane words = addr+1 (a), addr+1+8*lane (w); junk otherwise.
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (bus.rd_en) begin
                bus.a_vec[i*DW +: DW] <= 8'(bus.rd_addr) + 8'd1;
                bus.w_vec[i*DW +: DW] <= 8'(bus.rd_addr) + 8'd1 + 8'(8 * i);
            end else begin
                bus.a_vec[i*DW +: DW] <= 8'hA5;
                bus.w_vec[i*DW +: DW] <= 8'h5A;
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cyc=%0d: actual=%0d required=%0d", nm, cyc, act, exp);
        end
    endtask

    // Expected events of a job started at t0; only events at relative cycle <= cut.
    task automatic push_exp(input int t0, input int k, input int cut);
        int last;
        last = k + 2 * N + 2;
        if (k == 0) begin
            busy_q.push_back(t0 + 1);
            done_q.push_back(t0 + 1);
        end else begin
            if (cut >= 1) clr_q.push_back(t0 + 1);
            for (int c = 1; c <= last && c <= cut; c++) busy_q.push_back(t0 + c);
            for (int a = 0; a < k; a++) begin
                if (2 + a <= cut) begin
                    rd_cyc_q.push_back(t0 + 2 + a);
                    rd_addr_q.push_back(a);
                end
            end
            for (int c = 3; c <= k + N + 1 && c <= cut; c++) begin
                for (int i = 0; i < N; i++) begin
                    int idx;
                    idx = c - 3 - i;
                    if (idx >= 0 && idx < k) skew_q.push_back('{t0 + c, i, idx + 1, idx + 1 + 8 * i});
                end
            end
            if (last <= cut) done_q.push_back(t0 + last);
        end
    endtask

    task automatic start_job(input int k, input int cut, output int t0);
        @(negedge clk);
        bus.start = 1'b1;
        bus.k_len = 8'(k);
        t0 = cyc;
        push_exp(t0, k, cut);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Monitor: any asserted output must match the head of its expectation queue.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.arr_clr !== 1'b0) begin
                if (clr_q.size() == 0) check("arr_clr_unexpected", cyc, -1);
                else check("arr_clr_cycle", cyc, clr_q.pop_front());
            end
            if (bus.busy !== 1'b0) begin
                if (busy_q.size() == 0) check("busy_unexpected", cyc, -1);
                else check("busy_cycle", cyc, busy_q.pop_front());
            end
            if (bus.done !== 1'b0) begin
                if (done_q.size() == 0) check("done_unexpected", cyc, -1);
                else check("done_cycle", cyc, done_q.pop_front());
            end
            if (bus.rd_en !== 1'b0) begin
                if (rd_cyc_q.size() == 0) check("rd_unexpected", cyc, -1);
                else begin
                    check("rd_cycle", cyc, rd_cyc_q.pop_front());
                    check("rd_addr", 32'(bus.rd_addr), rd_addr_q.pop_front());
                end
            end
            for (int i = 0; i < N; i++) begin
                logic [DW-1:0] av, wv;
                av = bus.a_skew[i*DW +: DW];
                wv = bus.w_skew[i*DW +: DW];
                if (av !== '0 || wv !== '0) begin
                    if (skew_q.size() == 0) check("skew_unexpected", cyc, -1);
                    else begin
                        skew_t e;
                        e = skew_q.pop_front();
                        check("skew_cycle", cyc, e.c);
                        check("skew_lane", i, e.lane);
                        check("a_skew_val", 32'(av), e.a);
                        check("w_skew_val", 32'(wv), e.w);
                    end
                end
            end
        end
    end

    initial begin
        int t0;
        cyc       = 0;
        mon_en    = 1'b0;
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.k_len = '0;

        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_arr_clr", 32'(bus.arr_clr), 0);
        check("rst_rd_en", 32'(bus.rd_en), 0);
        check("rst_rd_addr", 32'(bus.rd_addr), 0);
        check("rst_a_skew", 32'(bus.a_skew), 0);
        check("rst_w_skew", 32'(bus.w_skew), 0);
`ifdef MAC_SCHED_PERF_EN
        check("rst_perf", perf_cycles, 0);
`endif
        rst    = 1'b0;
        mon_en = 1'b1;

        // k=3 job: done at cycle 13.
        start_job(3, 1000, t0);
        while (cyc < t0 + 16) @(negedge clk);
`ifdef MAC_SCHED_PERF_EN
        check("perf_k3", perf_cycles, 13);
`endif

        // k=0 job: straight to DONE.
        start_job(0, 1000, t0);
        while (cyc < t0 + 4) @(negedge clk);
`ifdef MAC_SCHED_PERF_EN
        check("perf_k0", perf_cycles, 1);
        repeat (3) @(negedge clk);
        check("perf_hold", perf_cycles, 1);
`endif

        // start held high with k=2; k_len changed mid-job; restart accepted at cycle 13.
        @(negedge clk);
        bus.start = 1'b1;
        bus.k_len = 8'd2;
        t0 = cyc;
        push_exp(t0, 2, 1000);
        push_exp(t0 + 13, 1, 1000);
        while (cyc < t0 + 5) @(negedge clk);
        bus.k_len = 8'd1;
        while (cyc < t0 + 14) @(negedge clk);
        bus.start = 1'b0;
        while (cyc < t0 + 28) @(negedge clk);

        // Reset at cycle 3 of a k=5 job.
        start_job(5, 3, t0);
        while (cyc < t0 + 3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", 32'(bus.busy), 0);
        check("midrst_done", 32'(bus.done), 0);
        check("midrst_arr_clr", 32'(bus.arr_clr), 0);
        check("midrst_rd_en", 32'(bus.rd_en), 0);
        check("midrst_rd_addr", 32'(bus.rd_addr), 0);
        check("midrst_a_skew", 32'(bus.a_skew), 0);
        check("midrst_w_skew", 32'(bus.w_skew), 0);
        repeat (15) @(negedge clk);

        // Normal job after the aborted one.
        start_job(2, 1000, t0);
        while (cyc < t0 + 16) @(negedge clk);

        check("left_clr", clr_q.size(), 0);
        check("left_busy", busy_q.size(), 0);
        check("left_done", done_q.size(), 0);
        check("left_rd", rd_cyc_q.size(), 0);
        check("left_skew", skew_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
